// File: rtl/if_fetch_if.sv
// Instruction-bus handshake between the fetch stage and instruction memory.
// req/addr are held stable until ack; data is valid only with ack.
interface if_fetch_if;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_data_i;

  modport master (output ibus_req_o, ibus_addr_o, input ibus_ack_i, ibus_data_i);
  modport slave  (input ibus_req_o, ibus_addr_o, output ibus_ack_i, ibus_data_i);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction bus, and handles
// wait states, flush while a request is outstanding, branches and misaligned PCs.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  if_fetch_if.master  ibus,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] excepttype_o,
  output logic        stallreq_o
);

  localparam logic [31:0] EXC_ADEL = 32'h00000004;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] next_pc;
  logic [31:0] target;
  logic        enter;

  // stall[1] belongs to the IF/ID register, not to this stage
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      buf_q   <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state: 'enter' starts a new fetch at 'target' (or faults if misaligned)
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    target  = pc_q;
    enter   = 1'b0;
    next_pc = branch_flag_i ? branch_target_address_i : pc_q + PC_STEP;

    if (flush) begin
      pc_d   = new_pc;
      target = new_pc;
      case (state_q)
        REQ:     if (ibus.ibus_ack_i) enter = 1'b1; else state_d = DRAIN;
        DRAIN:   if (ibus.ibus_ack_i) enter = 1'b1;
        default: enter = 1'b1;
      endcase
    end else begin
      case (state_q)
        IDLE: enter = 1'b1;
        REQ: begin
          if (ibus.ibus_ack_i) begin
            buf_d = ibus.ibus_data_i;
            if (!stall[0]) begin
              pc_d   = next_pc;
              target = next_pc;
              enter  = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall[0]) begin
            pc_d   = next_pc;
            target = next_pc;
            enter  = 1'b1;
          end
        end
        DRAIN:   if (ibus.ibus_ack_i) enter = 1'b1;
        default: ;
      endcase
    end

    if (enter) begin
      addr_d  = target;
      state_d = (target[1:0] != 2'b00) ? FAULT : REQ;
    end
  end

  always_comb begin
    ibus.ibus_req_o  = (state_q == REQ) || (state_q == DRAIN);
    ibus.ibus_addr_o = addr_q;
    pc_o             = pc_q;
    stallreq_o       = (state_q == REQ) && !ibus.ibus_ack_i;
    excepttype_o     = (state_q == FAULT) ? EXC_ADEL : 32'h0;
    inst_o           = NOP_INST;
    if ((state_q == REQ) && ibus.ibus_ack_i) inst_o = ibus.ibus_data_i;
    else if (state_q == HOLD)                inst_o = buf_q;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a per-cycle vector table from reset release,
// followed by an asynchronous reset applied in the middle of a fetch.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] pc_o, inst_o, excepttype_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  if_fetch_if ibus ();

  if_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .ibus                    (ibus),
    .pc_o                    (pc_o),
    .inst_o                  (inst_o),
    .excepttype_o            (excepttype_o),
    .stallreq_o              (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  st;
    logic        fl;
    logic [31:0] npc;
    logic        br;
    logic [31:0] bt;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_exc;
    logic        e_sr;
  } vec_t;

  localparam int unsigned NVEC = 31;
  vec_t vecs [NVEC];

  function automatic vec_t v(input logic [5:0] st, input logic fl, input logic [31:0] npc,
                             input logic br, input logic [31:0] bt, input logic ack,
                             input logic [31:0] data, input logic e_req, input logic [31:0] e_addr,
                             input logic [31:0] e_pc, input logic [31:0] e_inst,
                             input logic [31:0] e_exc, input logic e_sr);
    vec_t r;
    r.st = st; r.fl = fl; r.npc = npc; r.br = br; r.bt = bt; r.ack = ack; r.data = data;
    r.e_req = e_req; r.e_addr = e_addr; r.e_pc = e_pc; r.e_inst = e_inst;
    r.e_exc = e_exc; r.e_sr = e_sr;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    stall                   = x.st;
    flush                   = x.fl;
    new_pc                  = x.npc;
    branch_flag_i           = x.br;
    branch_target_address_i = x.bt;
    ibus.ibus_ack_i         = x.ack;
    ibus.ibus_data_i        = x.data;
  endtask

  task automatic check_row(input int i, input vec_t x);
    check($sformatf("row%0d req", i), 32'(ibus.ibus_req_o), 32'(x.e_req));
    if (x.e_req) check($sformatf("row%0d addr", i), ibus.ibus_addr_o, x.e_addr);
    check($sformatf("row%0d pc", i), pc_o, x.e_pc);
    check($sformatf("row%0d inst", i), inst_o, x.e_inst);
    check($sformatf("row%0d exc", i), excepttype_o, x.e_exc);
    check($sformatf("row%0d stallreq", i), 32'(stallreq_o), 32'(x.e_sr));
  endtask

  localparam logic [31:0] B = 32'hBFC00000;
  localparam logic [31:0] Z = 32'h0;

  initial begin
    // idle, then 3 wait states on the first fetch
    vecs[0]  = v(6'h00, 0, Z, 0, Z, 0, Z,            0, Z,         B,          Z,            Z, 0);
    vecs[1]  = v(6'h00, 0, Z, 0, Z, 0, Z,            1, B,         B,          Z,            Z, 1);
    vecs[2]  = v(6'h00, 0, Z, 0, Z, 0, Z,            1, B,         B,          Z,            Z, 1);
    vecs[3]  = v(6'h00, 0, Z, 0, Z, 0, Z,            1, B,         B,          Z,            Z, 1);
    vecs[4]  = v(6'h00, 0, Z, 0, Z, 1, 32'h24000000, 1, B,         B,          32'h24000000, Z, 0);
    // zero-wait back-to-back
    vecs[5]  = v(6'h00, 0, Z, 0, Z, 1, 32'h24000004, 1, B+4,       B+4,        32'h24000004, Z, 0);
    vecs[6]  = v(6'h00, 0, Z, 0, Z, 1, 32'h24000008, 1, B+8,       B+8,        32'h24000008, Z, 0);
    // ack under stall -> HOLD for 2 cycles, then pc+4
    vecs[7]  = v(6'h03, 0, Z, 0, Z, 1, 32'h2400000C, 1, B+12,      B+12,       32'h2400000C, Z, 0);
    vecs[8]  = v(6'h03, 0, Z, 0, Z, 0, Z,            0, Z,         B+12,       32'h2400000C, Z, 0);
    vecs[9]  = v(6'h00, 0, Z, 0, Z, 0, Z,            0, Z,         B+12,       32'h2400000C, Z, 0);
    // flush while request outstanding -> DRAIN until ack
    vecs[10] = v(6'h00, 1, 32'h80000180, 0, Z, 0, Z, 1, B+16,      B+16,       Z,            Z, 1);
    vecs[11] = v(6'h00, 0, Z, 0, Z, 0, Z,            1, B+16,      32'h80000180, Z,          Z, 0);
    vecs[12] = v(6'h00, 0, Z, 0, Z, 1, 32'hDEADBEEF, 1, B+16,      32'h80000180, Z,          Z, 0);
    // branch at ack
    vecs[13] = v(6'h00, 0, Z, 1, 32'h80001000, 1, 32'h24000180, 1, 32'h80000180, 32'h80000180, 32'h24000180, Z, 0);
    // branch held under stall, used at release
    vecs[14] = v(6'h01, 0, Z, 0, Z, 1, 32'h24001000, 1, 32'h80001000, 32'h80001000, 32'h24001000, Z, 0);
    vecs[15] = v(6'h01, 0, Z, 1, 32'h80002000, 0, Z, 0, Z,         32'h80001000, 32'h24001000, Z, 0);
    vecs[16] = v(6'h00, 0, Z, 1, 32'h80002000, 0, Z, 0, Z,         32'h80001000, 32'h24001000, Z, 0);
    vecs[17] = v(6'h00, 0, Z, 0, Z, 0, Z,            1, 32'h80002000, 32'h80002000, Z,        Z, 1);
    // flush with ack to misaligned target -> FAULT, stall ignored
    vecs[18] = v(6'h00, 1, 32'h80000182, 0, Z, 1, 32'h00000011, 1, 32'h80002000, 32'h80002000, 32'h00000011, Z, 0);
    vecs[19] = v(6'h01, 0, Z, 0, Z, 0, Z,            0, Z,         32'h80000182, Z,          32'h4, 0);
    vecs[20] = v(6'h00, 0, Z, 0, Z, 0, Z,            0, Z,         32'h80000182, Z,          32'h4, 0);
    vecs[21] = v(6'h00, 1, 32'h80000180, 0, Z, 0, Z, 0, Z,         32'h80000182, Z,          32'h4, 0);
    vecs[22] = v(6'h00, 0, Z, 0, Z, 1, 32'h24000180, 1, 32'h80000180, 32'h80000180, 32'h24000180, Z, 0);
    vecs[23] = v(6'h00, 0, Z, 0, Z, 0, Z,            1, 32'h80000184, 32'h80000184, Z,        Z, 1);
    // flush into DRAIN, then flush again with ack in the same cycle
    vecs[24] = v(6'h00, 1, 32'h80000200, 0, Z, 0, Z, 1, 32'h80000184, 32'h80000184, Z,        Z, 1);
    vecs[25] = v(6'h00, 1, 32'h80000300, 0, Z, 1, 32'h0000BEEF, 1, 32'h80000184, 32'h80000200, Z, Z, 0);
    vecs[26] = v(6'h00, 0, Z, 0, Z, 1, 32'h00000005, 1, 32'h80000300, 32'h80000300, 32'h00000005, Z, 0);
    vecs[27] = v(6'h00, 0, Z, 0, Z, 0, Z,            1, 32'h80000304, 32'h80000304, Z,        Z, 1);
    // branch to top of address space, pc+4 wraps to 0
    vecs[28] = v(6'h00, 0, Z, 1, 32'hFFFFFFFC, 1, 32'h00000006, 1, 32'h80000304, 32'h80000304, 32'h00000006, Z, 0);
    vecs[29] = v(6'h00, 0, Z, 0, Z, 1, 32'h00000007, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000007, Z, 0);
    vecs[30] = v(6'h00, 0, Z, 0, Z, 0, Z,            1, Z,         Z,          Z,            Z, 1);

    rst = 1'b0;
    drive(vecs[0]);
    #12;
    check("reset req", 32'(ibus.ibus_req_o), 32'h0);
    check("reset addr", ibus.ibus_addr_o, Z);
    check("reset pc", pc_o, B);
    check("reset inst", inst_o, Z);
    check("reset exc", excepttype_o, Z);
    check("reset stallreq", 32'(stallreq_o), 32'h0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < int'(NVEC); i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      check_row(i, vecs[i]);
    end

    // async reset mid-request: outputs must return to reset values without a clock edge
    @(negedge clk);
    drive(v(6'h00, 0, Z, 0, Z, 0, Z, 0, Z, Z, Z, Z, 0));
    #1;
    check("pre-areset stallreq", 32'(stallreq_o), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check("areset pc", pc_o, B);
    check("areset req", 32'(ibus.ibus_req_o), 32'h0);
    check("areset stallreq", 32'(stallreq_o), 32'h0);
    check("areset inst", inst_o, Z);
    @(negedge clk);
    rst = 1'b1;
    ibus.ibus_ack_i  = 1'b1;
    ibus.ibus_data_i = 32'h12345678;
    #1;
    check("post-areset idle req", 32'(ibus.ibus_req_o), 32'h0);
    check("post-areset idle inst", inst_o, Z);
    @(negedge clk);
    #1;
    check("post-areset req", 32'(ibus.ibus_req_o), 32'h1);
    check("post-areset addr", ibus.ibus_addr_o, B);
    check("post-areset inst", inst_o, 32'h12345678);
    @(negedge clk);
    #1;
    check("post-areset next addr", ibus.ibus_addr_o, B + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
